// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice: FSM states,
// the length-field position in word0, the default halt opcode and 96-bit word slicing.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OPC_W  = 8;

  localparam int unsigned LEN_LO = 30;
  localparam int unsigned LEN_W  = 2;
  localparam logic [LEN_W-1:0] LEN_ILLEGAL = 2'b11;

  localparam logic [OPC_W-1:0] HALT_OP_DEFAULT = 8'hFF;

  localparam int unsigned W0_LO = 0;
  localparam int unsigned W1_LO = WORD_W;
  localparam int unsigned W2_LO = 2 * WORD_W;
  localparam int unsigned FETCH_W = 3 * WORD_W;

endpackage

// File: rtl/instr_fetch_decode.sv
// Combinational word0 decoder: opcode, length in words, illegal-length flag,
// and operands with absent words forced to zero.
module instr_decode
  import instr_fetch_pkg::*;
(
  input  logic [FETCH_W-1:0] rom_data,
  output logic [OPC_W-1:0]   opcode,
  output logic [LEN_W-1:0]   len,
  output logic               illegal,
  output logic [WORD_W-1:0]  op1,
  output logic [WORD_W-1:0]  op2
);

  logic [LEN_W-1:0] len_field;

  always_comb begin
    len_field = rom_data[W0_LO + LEN_LO +: LEN_W];
    opcode    = rom_data[W0_LO +: OPC_W];
    illegal   = (len_field == LEN_ILLEGAL);
    len       = len_field + 2'd1;
    op1       = '0;
    op2       = '0;
    if (!illegal && len_field >= 2'd1) op1 = rom_data[W1_LO +: WORD_W];
    if (!illegal && len_field == 2'd2) op2 = rom_data[W2_LO +: WORD_W];
  end

endmodule

// File: rtl/instr_fetch.sv
// Variable-length instruction fetch with a one-deep output register, branch redirect,
// HALT/FAULT states. Define INSTR_FETCH_BOUNDS_CHECK_EN to fault on PC+len > PROG_LEN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned      PROG_LEN = 58,
  parameter logic [OPC_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WORD_W-1:0]    rom_addr,
  input  logic [FETCH_W-1:0]   rom_data,
  input  logic                 br_valid,
  input  logic [WORD_W-1:0]    br_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_pc,
  output logic [OPC_W-1:0]     out_opcode,
  output logic [LEN_W-1:0]     out_len,
  output logic [WORD_W-1:0]    out_op1,
  output logic [WORD_W-1:0]    out_op2,
  output logic                 out_halted,
  output logic                 out_fault
);

`ifdef INSTR_FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t            state, state_nx;
  logic [WORD_W-1:0] pc;
  logic [OPC_W-1:0]  dec_opcode;
  logic [LEN_W-1:0]  dec_len;
  logic              dec_illegal;
  logic [WORD_W-1:0] dec_op1, dec_op2;
  logic [WORD_W:0]   pc_end;
  logic              oob, load_req, fault_req, do_load;

  instr_decode u_decode (
    .rom_data (rom_data),
    .opcode   (dec_opcode),
    .len      (dec_len),
    .illegal  (dec_illegal),
    .op1      (dec_op1),
    .op2      (dec_op2)
  );

  assign rom_addr = pc;

  // Bounds compare is done one bit wider so a PC near the top of the space cannot wrap past it.
  always_comb begin
    pc_end = {1'b0, pc} + {{(WORD_W-1){1'b0}}, dec_len};
    oob    = BOUNDS_EN && (pc_end > (WORD_W+1)'(PROG_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN: begin
        if (fault_req)                               state_nx = ST_FAULT;
        else if (do_load && dec_opcode == HALT_OP)   state_nx = ST_HALT;
      end
      ST_HALT:  if (br_valid) state_nx = ST_RUN;
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_FAULT;
    endcase
  end

  always_comb begin
    load_req   = (state == ST_RUN) && !br_valid && (!out_valid || out_ready);
    fault_req  = load_req && (dec_illegal || oob);
    do_load    = load_req && !fault_req;
    out_halted = (state == ST_HALT);
    out_fault  = (state == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_opcode <= '0;
      out_len    <= 2'd1;
      out_op1    <= '0;
      out_op2    <= '0;
    end else if (state == ST_FAULT || fault_req) begin
      out_valid <= 1'b0;
    end else if (br_valid) begin
      out_valid <= 1'b0;
      pc        <= br_target;
    end else if (do_load) begin
      out_valid  <= 1'b1;
      out_pc     <= pc;
      out_opcode <= dec_opcode;
      out_len    <= dec_len;
      out_op1    <= dec_op1;
      out_op2    <= dec_op2;
      pc         <= pc + {{(WORD_W-LEN_W){1'b0}}, dec_len};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written fault/reset/bounds
// sequences, then randomized traffic against a program-walk reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr;
  logic [95:0] rom_data;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [7:0]  out_opcode;
  logic [1:0]  out_len;
  logic [31:0] out_op1, out_op2;
  logic        out_halted, out_fault;

  logic [31:0] rom [0:255];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  instr_fetch #(.PROG_LEN(58), .HALT_OP(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_len    (out_len),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_halted (out_halted),
    .out_fault  (out_fault)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [7:0] a0;
    a0 = rom_addr[7:0];
    rom_data = {rom[a0 + 8'd2], rom[a0 + 8'd1], rom[a0]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, rdy, br;
    logic [31:0] tgt;
    logic        chk_rec;
    logic        v;
    logic [31:0] pc;
    logic [7:0]  opc;
    logic [1:0]  len;
    logic [31:0] op1, op2;
    logic        h, f;
    logic [31:0] ra;
  } vec_t;

  function automatic vec_t mk(logic r, logic rdy, logic br, logic [31:0] tgt, logic cr, logic v,
                              logic [31:0] pc, logic [7:0] opc, logic [1:0] len,
                              logic [31:0] op1, logic [31:0] op2, logic h, logic f, logic [31:0] ra);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.br = br; t.tgt = tgt; t.chk_rec = cr; t.v = v;
    t.pc = pc; t.opc = opc; t.len = len; t.op1 = op1; t.op2 = op2;
    t.h = h; t.f = f; t.ra = ra;
    return t;
  endfunction

  // Reference: length of the instruction starting at word address a.
  function automatic int unsigned mlen(int unsigned a);
    logic [31:0] w;
    w = rom[a % 256];
    return int'(w[31:30]) + 1;
  endfunction

  initial begin
    vec_t vt [0:15];
    int unsigned exp_pc;
    int unsigned ml;
    logic prev_br;
    logic [31:0] w;

    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 32'h0000_0001;  rom[1] = 32'h4000_0002;  rom[2] = 32'd5;
    rom[3] = 32'h8000_0003;  rom[4] = 32'd7;          rom[5] = 32'd9;
    rom[6] = 32'h0000_00FF;  rom[10] = 32'h0000_000A;
    rom[20] = 32'hC000_0004; rom[57] = 32'h4000_0039; rom[58] = 32'h0000_1234;

    vt[0]  = mk(1,1,0, 0, 1, 0, 0, 8'h00,1, 0,0, 0,0, 0);
    vt[1]  = mk(0,1,0, 0, 1, 1, 0, 8'h01,1, 0,0, 0,0, 1);
    vt[2]  = mk(0,1,0, 0, 1, 1, 1, 8'h02,2, 5,0, 0,0, 3);
    for (int i = 3; i <= 6; i++) vt[i] = mk(0,0,0, 0, 1, 1, 1, 8'h02,2, 5,0, 0,0, 3);
    vt[7]  = mk(0,1,0, 0, 1, 1, 3, 8'h03,3, 7,9, 0,0, 6);
    vt[8]  = mk(0,1,1,10, 0, 0, 0, 8'h00,1, 0,0, 0,0, 10);
    vt[9]  = mk(0,1,0, 0, 1, 1,10, 8'h0A,1, 0,0, 0,0, 11);
    vt[10] = mk(0,1,1, 6, 0, 0, 0, 8'h00,1, 0,0, 0,0, 6);
    vt[11] = mk(0,0,0, 0, 1, 1, 6, 8'hFF,1, 0,0, 1,0, 7);
    vt[12] = mk(0,1,0, 0, 0, 0, 0, 8'h00,1, 0,0, 1,0, 7);
    vt[13] = mk(0,1,0, 0, 0, 0, 0, 8'h00,1, 0,0, 1,0, 7);
    vt[14] = mk(0,0,1, 0, 0, 0, 0, 8'h00,1, 0,0, 0,0, 0);
    vt[15] = mk(0,1,0, 0, 1, 1, 0, 8'h01,1, 0,0, 0,0, 1);

    #2;
    for (int i = 0; i < 16; i++) begin
      rst = vt[i].rst; out_ready = vt[i].rdy; br_valid = vt[i].br; br_target = vt[i].tgt;
      tick();
      chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vt[i].v));
      chk($sformatf("v%0d.halted", i), 32'(out_halted), 32'(vt[i].h));
      chk($sformatf("v%0d.fault", i), 32'(out_fault), 32'(vt[i].f));
      chk($sformatf("v%0d.rom_addr", i), rom_addr, vt[i].ra);
      if (vt[i].chk_rec) begin
        chk($sformatf("v%0d.pc", i), out_pc, vt[i].pc);
        chk($sformatf("v%0d.opcode", i), 32'(out_opcode), 32'(vt[i].opc));
        chk($sformatf("v%0d.len", i), 32'(out_len), 32'(vt[i].len));
        chk($sformatf("v%0d.op1", i), out_op1, vt[i].op1);
        chk($sformatf("v%0d.op2", i), out_op2, vt[i].op2);
      end
    end

    // Illegal length: FAULT is sticky through branches, cleared only by reset.
    br_valid = 1'b1; br_target = 32'd20; out_ready = 1'b1;
    tick();
    br_valid = 1'b0;
    tick();
    chk("fault.flag", 32'(out_fault), 32'd1);
    chk("fault.valid", 32'(out_valid), 32'd0);
    br_valid = 1'b1; br_target = 32'd0;
    repeat (2) tick();
    chk("fault.br_flag", 32'(out_fault), 32'd1);
    chk("fault.br_valid", 32'(out_valid), 32'd0);
    br_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("fault.rst_flag", 32'(out_fault), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("fault.rst_resume", 32'(out_valid), 32'd1);
    chk("fault.rst_pc", out_pc, 32'd0);

    // Reset asserted mid-stall drops the held record immediately.
    out_ready = 1'b0;
    repeat (2) tick();
    chk("stall.valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("stall.rst_valid", 32'(out_valid), 32'd0);
    chk("stall.rst_len", 32'(out_len), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stall.post_rst_valid", 32'(out_valid), 32'd0);
    tick();
    chk("stall.first_valid", 32'(out_valid), 32'd1);
    chk("stall.first_pc", out_pc, 32'd0);

    // PC=57 with a 2-word instruction crosses PROG_LEN.
    br_valid = 1'b1; br_target = 32'd57; out_ready = 1'b1;
    tick();
    br_valid = 1'b0;
    tick();
`ifdef INSTR_FETCH_BOUNDS_CHECK_EN
    chk("bounds.fault", 32'(out_fault), 32'd1);
    chk("bounds.valid", 32'(out_valid), 32'd0);
`else
    chk("bounds.valid", 32'(out_valid), 32'd1);
    chk("bounds.pc", out_pc, 32'd57);
    chk("bounds.op1", out_op1, 32'h1234);
`endif

    // Randomized run over a program with only legal, non-halt words.
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      w[31:30] = 2'($urandom_range(0, 2));
      if (w[7:0] == 8'hFF) w[7:0] = 8'h00;
      rom[i] = w;
    end
    rst = 1'b1; br_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_pc = 0;
    prev_br = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      chk("rnd.valid", 32'(out_valid), prev_br ? 32'd0 : 32'd1);
      if (out_valid) begin
        ml = mlen(exp_pc);
        chk("rnd.pc", out_pc, exp_pc);
        chk("rnd.opcode", 32'(out_opcode), 32'(rom[exp_pc % 256][7:0]));
        chk("rnd.len", 32'(out_len), ml);
        chk("rnd.op1", out_op1, (ml >= 2) ? rom[(exp_pc + 1) % 256] : 32'd0);
        chk("rnd.op2", out_op2, (ml == 3) ? rom[(exp_pc + 2) % 256] : 32'd0);
        chk("rnd.rom_addr", rom_addr, exp_pc + ml);
      end
      br_valid  = (exp_pc >= 40) || ($urandom_range(0, 15) == 0);
      br_target = $urandom_range(0, 39);
      out_ready = ($urandom_range(0, 3) != 0);
      if (br_valid) exp_pc = br_target;
      else if (out_valid && out_ready) exp_pc = exp_pc + mlen(exp_pc);
      prev_br = br_valid;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
